// File: rtl/uart_image_loader_if.sv
// Byte-stream and BRAM write-port bundle for the UART image loader.
// The master side (loader) consumes rx bytes and drives the response and BRAM write port.
interface uart_image_loader_if #(
    parameter int unsigned ADDR_W = 10
) ();
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              tx_ready;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              bram_wr_en;
    logic [ADDR_W-1:0] bram_wr_addr;
    logic [7:0]        bram_wr_data;

    modport master (
        input  rx_valid, rx_data, tx_ready,
        output tx_valid, tx_data, bram_wr_en, bram_wr_addr, bram_wr_data
    );

    modport slave (
        output rx_valid, rx_data, tx_ready,
        input  tx_valid, tx_data, bram_wr_en, bram_wr_addr, bram_wr_data
    );
endinterface

// File: rtl/uart_image_loader.sv
// Frame parser: A5 5A header, PIX_NUM pixels into BRAM, 8-bit sum check, ACK/NAK reply.
// All outputs are registered; the comb process computes the next value of every register.
module uart_image_loader #(
    parameter int unsigned PIX_NUM        = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 500_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                bram_wr_start,
    uart_image_loader_if.master bus,
    output logic                load_busy,
    output logic                load_done,
    output logic                load_err
);
    localparam int unsigned CNT_W = $clog2(PIX_NUM);
    localparam int unsigned GAP_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]  HDR_A = 8'hA5;
    localparam logic [7:0]  HDR_B = 8'h5A;
    localparam logic [7:0]  ACK   = 8'h06;
    localparam logic [7:0]  NAK   = 8'h15;

    typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_DATA, S_CSUM, S_RESP} state_t;

    state_t             r_state, w_state;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic [7:0]         r_sum, w_sum;
    logic [GAP_W-1:0]   r_gap, w_gap;
    logic               r_tx_valid, w_tx_valid;
    logic [7:0]         r_tx_data, w_tx_data;
    logic               r_wr_en, w_wr_en;
    logic [CNT_W-1:0]   r_wr_addr, w_wr_addr;
    logic [7:0]         r_wr_data, w_wr_data;
    logic               r_busy, w_busy;
    logic               r_done, w_done;
    logic               r_err, w_err;
    logic               w_timed;
    logic               w_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_sum      <= '0;
            r_gap      <= '0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_sum      <= w_sum;
            r_gap      <= w_gap;
            r_tx_valid <= w_tx_valid;
            r_tx_data  <= w_tx_data;
            r_wr_en    <= w_wr_en;
            r_wr_addr  <= w_wr_addr;
            r_wr_data  <= w_wr_data;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_err      <= w_err;
        end
    end

    // Inter-byte gap only matters once a header byte has been seen.
    assign w_timed   = (r_state == S_HDR1) || (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_timeout = w_timed && (r_gap == GAP_W'(TIMEOUT_CYCLES));

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_sum      = r_sum;
        w_gap      = '0;
        w_tx_valid = r_tx_valid;
        w_tx_data  = r_tx_data;
        w_wr_en    = 1'b0;
        w_wr_addr  = r_wr_addr;
        w_wr_data  = r_wr_data;
        w_done     = r_done;
        w_err      = r_err;

        if (w_timed) begin
            w_gap = bus.rx_valid ? '0 : r_gap + GAP_W'(1);
        end

        // Arm wins over timeout and over any byte arriving in the same cycle.
        if (bram_wr_start) begin
            w_state    = S_HDR0;
            w_cnt      = '0;
            w_sum      = '0;
            w_gap      = '0;
            w_tx_valid = 1'b0;
            w_done     = 1'b0;
            w_err      = 1'b0;
        end else if (w_timeout) begin
            w_state    = S_RESP;
            w_err      = 1'b1;
            w_tx_data  = NAK;
            w_tx_valid = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: ;
                S_HDR0: begin
                    if (bus.rx_valid && bus.rx_data == HDR_A) w_state = S_HDR1;
                end
                S_HDR1: begin
                    if (bus.rx_valid) begin
                        if (bus.rx_data == HDR_B)      w_state = S_DATA;
                        else if (bus.rx_data != HDR_A) w_state = S_HDR0;
                    end
                end
                S_DATA: begin
                    if (bus.rx_valid) begin
                        w_wr_en   = 1'b1;
                        w_wr_addr = r_cnt;
                        w_wr_data = bus.rx_data;
                        w_sum     = r_sum + bus.rx_data;
                        if (r_cnt == CNT_W'(PIX_NUM - 1)) w_state = S_CSUM;
                        else                              w_cnt   = r_cnt + CNT_W'(1);
                    end
                end
                S_CSUM: begin
                    if (bus.rx_valid) begin
                        w_state    = S_RESP;
                        w_tx_valid = 1'b1;
                        if (bus.rx_data == r_sum) begin
                            w_done    = 1'b1;
                            w_tx_data = ACK;
                        end else begin
                            w_err     = 1'b1;
                            w_tx_data = NAK;
                        end
                    end
                end
                S_RESP: begin
                    if (r_tx_valid && bus.tx_ready) begin
                        w_tx_valid = 1'b0;
                        w_state    = S_IDLE;
                    end
                end
                default: w_state = S_IDLE;
            endcase
        end

        w_busy = (w_state == S_HDR0) || (w_state == S_HDR1) ||
                 (w_state == S_DATA) || (w_state == S_CSUM);
    end

    assign bus.tx_valid     = r_tx_valid;
    assign bus.tx_data      = r_tx_data;
    assign bus.bram_wr_en   = r_wr_en;
    assign bus.bram_wr_addr = r_wr_addr;
    assign bus.bram_wr_data = r_wr_data;
    assign load_busy        = r_busy;
    assign load_done        = r_done;
    assign load_err         = r_err;
endmodule
